seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Sequences the 4-digit multiplexed 7-segment display: time-slots the shared cathode bus across the four anodes.
- Inserts a blanking gap between digits to prevent ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Decodes hex nibbles to cathodes, with optional leading-zero suppression; sits between the arithmetic result and the board display pins.

Parameters:
- ON_CYCLES, 100000, clocks each digit is lit per slot (>=1)
- BLANK_CYCLES, 1000, clocks all anodes are off before each digit slot (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  capture digits_in/dp_in/digit_en into shadow buffer this cycle
- digits_in  in  16  four hex nibbles; [3:0]=digit0 (rightmost) ... [15:12]=digit3
- dp_in  in  4  decimal point per digit, 1=on
- digit_en  in  4  per-digit enable, 1=display
- lz_en  in  1  leading-zero suppression enable (live, not buffered)
- seg_anode  out  4  active-low anode select
- seg_cathode  out  7  active-low segments {g,f,e,d,c,b,a}
- seg_dp  out  1  active-low decimal point
- frame_done  out  1  one-cycle pulse at end of each frame
- update_pending  out  1  shadow holds data not yet committed

Behaviour:
- Single clock; synchronous, active-low reset (rst_n sampled on rising clk).
- Reset:
  - state=BLANK, digit_idx=0, slot counter=0.
  - seg_anode=4'b1111, seg_cathode=7'b1111111, seg_dp=1.
  - frame_done=0, update_pending=0.
  - Active and shadow registers cleared: digits=0, dp=0, en=0 (display dark until the first load commits).
  - Reset mid-frame blanks on the next edge; any pending update is discarded.
- FSM, two states per digit slot:
  - BLANK: lasts exactly BLANK_CYCLES clocks; all anodes off, cathodes all 1, dp 1.
  - SHOW: lasts exactly ON_CYCLES clocks; anode for digit_idx asserted low only if the digit is visible; cathode/dp driven from the active register.
  - BLANK->SHOW when counter==BLANK_CYCLES-1. SHOW->BLANK when counter==ON_CYCLES-1; digit_idx increments mod 4 on that edge. Counter resets to 0 on every transition.
  - Frame length is fixed at 4*(BLANK_CYCLES+ON_CYCLES) clocks, regardless of enables or suppression.
- Outputs are registered and change on the same edge as the state transition (no extra latency).
- Visibility of digit i: en[i]=1 and not suppressed.
  - An invisible digit keeps its slot timing; anodes stay 4'b1111 throughout that slot.
- Leading-zero suppression (when lz_en=1), evaluated on the active register:
  - digit3 suppressed if nibble3==0.
  - digit2 suppressed if nibbles 3 and 2 ==0.
  - digit1 suppressed if nibbles 3..1 ==0.
  - digit0 never suppressed.
  - dp of a suppressed digit is also off.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Double buffer:
  - load=1 writes the shadow and sets update_pending=1; later loads overwrite the shadow (last wins).
  - Commit edge: SHOW->BLANK of digit3. On it, if pending, active<=shadow and pending<=0; frame_done=1 for exactly that one cycle.
  - load coincident with the commit edge: the incoming load data is committed directly (bypass) and pending ends 0.
- Counter width: clog2(max(ON_CYCLES,BLANK_CYCLES)); no overflow is possible.

Test Plan:
- Bench uses ON_CYCLES=3, BLANK_CYCLES=2, so frame=20 clocks.
1. Reset then idle, no load -> anodes stay 1111 and cathodes 1111111 for 40 clocks; frame_done pulses at clocks 20 and 40 after reset release; update_pending=0.
2. load digits_in=16'h12AF, en=1111, dp=0000 mid-frame -> update_pending=1 until the next commit. In the following frame: anodes 1110/1101/1011/0111 each for 3 clocks, separated by 2-clock 1111 gaps; cathodes 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1).
3. digits 16'h0050, lz_en=1, en=1111, dp=0100 -> digit3 and digit2 slots show anode 1111; digit1 shows 5 (0010010) with seg_dp=1; digit0 shows 0 (1000000). With lz_en=0, all four digits are lit and digit2 shows seg_dp=0.
4. Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is ever displayed. A load asserted exactly on the frame_done edge -> that data is displayed in the next frame and update_pending=0.
5. en=0101 with digits 16'h8888 -> only digit0 and digit2 are lit (8=0000000); frame_done period remains 20 clocks.
6. rst_n low for one cycle during digit2 SHOW -> next edge: anodes 1111, state BLANK digit0, active register cleared, pending cleared; display dark until a new load commits.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller: blank/show time slots per digit,
// hex decode with leading-zero suppression, and a frame-synchronous double buffer.
module seg_scan_ctrl #(
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [3:0]  seg_anode,
  output logic [6:0]  seg_cathode,
  output logic        seg_dp,
  output logic        frame_done,
  output logic        update_pending,
  output logic [2:0]  dbg_state_o
);

  localparam int MAX_C = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
  logic [3:0]       act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [3:0]       act_en_q, act_en_d, sh_en_q, sh_en_d;
  logic             pend_q, pend_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       cat_q, cat_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;
  logic             commit;
  logic [3:0]       supp, vis;
  logic [3:0]       nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    commit   = 1'b0;
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    pend_d   = pend_q;
    anode_d  = 4'hF;
    cat_d    = 7'h7F;
    dp_d     = 1'b1;
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      default: if (cnt_q == ON_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        commit  = (idx_q == 2'd3);
      end
    endcase
    if (load) begin
      sh_dig_d = digits_in;
      sh_dp_d  = dp_in;
      sh_en_d  = digit_en;
      pend_d   = 1'b1;
    end
    // A load landing on the commit edge bypasses the shadow straight to active.
    if (commit) begin
      if (load) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
        act_en_d  = digit_en;
      end else if (pend_q) begin
        act_dig_d = sh_dig_q;
        act_dp_d  = sh_dp_q;
        act_en_d  = sh_en_q;
      end
      pend_d = 1'b0;
    end
    // Outputs are computed from next-state so they switch on the transition edge.
    supp[3] = lz_en && (act_dig_d[15:12] == 4'h0);
    supp[2] = supp[3] && (act_dig_d[11:8] == 4'h0);
    supp[1] = supp[2] && (act_dig_d[7:4] == 4'h0);
    supp[0] = 1'b0;
    vis     = act_en_d & ~supp;
    nib     = act_dig_d[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW && vis[idx_d]) begin
      anode_d = ~(4'b0001 << idx_d);
      cat_d   = hex7(nib);
      dp_d    = ~act_dp_d[idx_d];
    end
    fd_d = commit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      act_dig_q <= 16'h0;
      act_dp_q  <= 4'h0;
      act_en_q  <= 4'h0;
      sh_dig_q  <= 16'h0;
      sh_dp_q   <= 4'h0;
      sh_en_q   <= 4'h0;
      pend_q    <= 1'b0;
      anode_q   <= 4'hF;
      cat_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      act_en_q  <= act_en_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      pend_q    <= pend_d;
      anode_q   <= anode_d;
      cat_q     <= cat_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_anode      = anode_q;
  assign seg_cathode    = cat_q;
  assign seg_dp         = dp_q;
  assign frame_done     = fd_q;
  assign update_pending = pend_q;
  assign dbg_state_o    = {idx_q, state_q == SHOW};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with ON_CYCLES=3, BLANK_CYCLES=2 (20-clock frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, load, lz_en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, digit_en;
  logic [3:0]  seg_anode;
  logic [6:0]  seg_cathode;
  logic        seg_dp, frame_done, update_pending;
  logic [2:0]  dbg_state_o;

  seg_scan_ctrl #(.ON_CYCLES(3), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .seg_anode(seg_anode), .seg_cathode(seg_cathode),
    .seg_dp(seg_dp), .frame_done(frame_done), .update_pending(update_pending),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] C_0 = 7'b1000000, C_1 = 7'b1111001, C_2 = 7'b0100100;
  localparam logic [6:0] C_5 = 7'b0010010, C_8 = 7'b0000000, C_A = 7'b0001000;
  localparam logic [6:0] C_C = 7'b1000110, C_D = 7'b0100001, C_E = 7'b0000110;
  localparam logic [6:0] C_F = 7'b0001110, C_X = 7'b1111111;

  int          n_cmp = 0;
  int          n_err = 0;
  int          k = 0;
  logic [13:0] exp_q[$];
  logic [3:0]  e_vis;
  logic [6:0]  e_cat[4];
  logic [3:0]  e_sdp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic set_exp(input logic [3:0] vis, input logic [6:0] c3, input logic [6:0] c2,
                         input logic [6:0] c1, input logic [6:0] c0, input logic [3:0] sdp);
    e_vis = vis;
    e_cat[3] = c3; e_cat[2] = c2; e_cat[1] = c1; e_cat[0] = c0;
    e_sdp = sdp;
  endtask

  task automatic adv(input int n, input logic exp_pend);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq("adv_frame_done", frame_done, 1'b0);
      check_eq("adv_pending", update_pending, exp_pend);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    load = 1'b1; digits_in = d; dp_in = dp; digit_en = en;
    tick();
    load = 1'b0;
    check_eq("load_pending", update_pending, 1'b1);
  endtask

  task automatic run_to_end();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (k % 20 == 0) begin
        check_eq("commit_pending", update_pending, 1'b0);
        check_eq("commit_frame_done", frame_done, 1'b1);
        break;
      end
      check_eq("wait_pending", update_pending, 1'b1);
    end
  endtask

  // Runs one whole frame from a frame boundary; optionally loads on the closing commit edge.
  task automatic run_frame(input logic edge_ld, input logic [15:0] ed,
                           input logic [3:0] edp, input logic [3:0] een);
    logic [13:0] w;
    int          tt, s;
    logic        sh;
    for (int i = 1; i <= 20; i++) begin
      tt = i % 20; s = tt / 5; sh = (tt % 5) >= 2;
      w = {1'b1, 4'hF, C_X, 1'b1, tt == 0};
      if (sh) begin
        if (e_vis[s]) w = {1'b1, ~(4'b0001 << s), e_cat[s], e_sdp[s], 1'b0};
        else w[13] = 1'b0;
      end
      exp_q.push_back(w);
    end
    for (int i = 1; i <= 20; i++) begin
      if (edge_ld && i == 20) begin
        load = 1'b1; digits_in = ed; dp_in = edp; digit_en = een;
      end
      tick();
      w  = exp_q.pop_front();
      tt = k % 20; s = tt / 5; sh = (tt % 5) >= 2;
      check_eq($sformatf("anode t%0d", tt), seg_anode, w[12:9]);
      if (w[13]) begin
        check_eq($sformatf("cathode t%0d", tt), seg_cathode, w[8:2]);
        check_eq($sformatf("dp t%0d", tt), seg_dp, w[1]);
      end
      check_eq($sformatf("frame_done t%0d", tt), frame_done, w[0]);
      check_eq($sformatf("pending t%0d", tt), update_pending, 1'b0);
      check_eq($sformatf("state t%0d", tt), dbg_state_o, {s[1:0], sh});
    end
    load = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_anode", seg_anode, 4'hF);
    check_eq("rst_cathode", seg_cathode, C_X);
    check_eq("rst_dp", seg_dp, 1'b1);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_pending", update_pending, 1'b0);
    check_eq("rst_state", dbg_state_o, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; lz_en = 1'b0;
    digits_in = 16'h0; dp_in = 4'h0; digit_en = 4'h0;
    tick(); tick();
    check_reset_outputs();
    rst_n = 1'b1; k = 0;

    // idle after reset: dark display, frame_done at clocks 20 and 40
    set_exp(4'b0000, C_X, C_X, C_X, C_X, 4'hF);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    // mid-frame load of 12AF
    adv(3, 1'b0);
    do_load(16'h12AF, 4'b0000, 4'b1111);
    run_to_end();
    set_exp(4'b1111, C_1, C_2, C_A, C_F, 4'b1111);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    // leading-zero suppression on 0050, then live disable
    lz_en = 1'b1;
    adv(2, 1'b0);
    do_load(16'h0050, 4'b0100, 4'b1111);
    run_to_end();
    set_exp(4'b0011, C_X, C_X, C_5, C_0, 4'b1111);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);
    lz_en = 1'b0;
    set_exp(4'b1111, C_0, C_0, C_5, C_0, 4'b1011);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    // two loads in one frame: last wins; then a load on the commit edge
    adv(2, 1'b0);
    do_load(16'h1111, 4'b0000, 4'b1111);
    adv(3, 1'b1);
    do_load(16'h2222, 4'b0000, 4'b1111);
    run_to_end();
    set_exp(4'b1111, C_2, C_2, C_2, C_2, 4'b1111);
    run_frame(1'b1, 16'hC0DE, 4'b1001, 4'b1111);
    set_exp(4'b1111, C_C, C_0, C_D, C_E, 4'b0110);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    // per-digit enables 0101 on 8888
    adv(2, 1'b0);
    do_load(16'h8888, 4'b0000, 4'b0101);
    run_to_end();
    set_exp(4'b0101, C_8, C_8, C_8, C_8, 4'b1111);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    // reset during digit2 SHOW with an update pending
    adv(4, 1'b0);
    do_load(16'h1234, 4'b1111, 4'b1111);
    adv(7, 1'b1);
    check_eq("pre_rst_anode", seg_anode, 4'b1011);
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1; k = 0;
    set_exp(4'b0000, C_X, C_X, C_X, C_X, 4'hF);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);
    run_frame(1'b0, 16'h0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
